// File: rtl/mem_fill_responder.sv
// Multi-cycle memory responder: single-word writes, fixed-latency single reads and
// critical-word-first wrapping line-fill bursts for the cache miss handler.
module mem_fill_responder #(
  parameter int LATENCY        = 4,
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W         = 16,
  parameter int MEM_WORDS      = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wr,
  input  logic              req_burst,
  input  logic [15:0]       req_wdata,
  output logic              rsp_valid,
  output logic [15:0]       rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_last,
  output logic              busy
);

  localparam int WA_W  = ADDR_W - 1;
  localparam int OFF_W = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [WA_W-1:0]  LINE_MASK = WA_W'(WORDS_PER_LINE - 1);
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_STREAM
  } state_t;

  state_t            state;
  logic [WA_W-1:0]   word_addr;
  logic [WA_W-1:0]   beat_word;
  logic [OFF_W-1:0]  beat_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              is_burst;
  logic [15:0]       beat_rdata;
  logic              wr_accept;

  logic [15:0] mem [MEM_WORDS];

  // Byte address bit 0 has no meaning for 16-bit words.
  logic unused_addr_lsb;
  assign unused_addr_lsb = req_addr[0];

  // Offset arithmetic is masked to the line so the beat order wraps inside it.
  assign beat_word  = (word_addr & ~LINE_MASK) | ((word_addr + WA_W'(beat_cnt)) & LINE_MASK);
  assign beat_rdata = mem[beat_word];

  // req_ready is only high in IDLE, so writes can never overlap a read.
  assign wr_accept = req_valid && req_ready && req_wr;

  // NOTE: storage has no reset branch; clearing it would cost a huge reset tree
  // and contents must survive a reset anyway.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[req_addr[ADDR_W-1:1]] <= req_wdata;
    end
  end

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      word_addr <= '0;
      beat_cnt  <= '0;
      lat_cnt   <= '0;
      is_burst  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready && !req_wr) begin
            word_addr <= req_addr[ADDR_W-1:1];
            is_burst  <= req_burst;
            beat_cnt  <= '0;
            lat_cnt   <= LAT_W'(LATENCY - 1);
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state     <= ST_STREAM;
            rsp_valid <= 1'b1;
            rsp_addr  <= {beat_word, 1'b0};
            rsp_data  <= beat_rdata;
            rsp_last  <= !is_burst || (WORDS_PER_LINE == 1);
            beat_cnt  <= beat_cnt + 1'b1;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end

        ST_STREAM: begin
          if (rsp_last) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end else begin
            rsp_addr <= {beat_word, 1'b0};
            rsp_data <= beat_rdata;
            rsp_last <= (beat_cnt == LAST_BEAT);
            beat_cnt <= beat_cnt + 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b0;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
